// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// A queued write request is an address/data pair.
package rf_wb_arbiter_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0]  wa;
      logic [DATA_W-1:0] wd;
   } wb_req_t;

   // Register 0 is hardwired, so a write to it is never a real request.
   function automatic logic is_live_reg(input logic [REG_W-1:0] wa);
      return wa != REG_ZERO;
   endfunction
endpackage

// File: rtl/rf_wb_queue.sv
// Circular FIFO of pending port B writes with per-entry valid bits.
// Entries can be squashed by address; squashed entries keep their slot.
module rf_wb_queue
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    push,
   input  logic [REG_W-1:0]        push_wa,
   input  logic [DATA_W-1:0]       push_wd,
   input  logic                    pop,
   input  logic                    squash,
   input  logic [REG_W-1:0]        squash_wa,
   input  logic [REG_W-1:0]        ra1,
   input  logic [REG_W-1:0]        ra2,
   output logic [REG_W-1:0]        head_wa,
   output logic [DATA_W-1:0]       head_wd,
   output logic                    head_vld,
   output logic [$clog2(DEPTH):0]  cnt,
   output logic                    pend1,
   output logic                    pend2
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_req_t           r_mem [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [DEPTH-1:0]  w_vld_next;
   logic [DEPTH-1:0]  w_hit1;
   logic [DEPTH-1:0]  w_hit2;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_push_vld;
   wb_req_t           w_push_req;

   // An incoming beat aimed at the register A is writing right now is already stale.
   assign w_push_vld = !(squash && (push_wa == squash_wa));
   assign w_push_req = '{wa: push_wa, wd: push_wd};

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign w_vld_next[gi] =
            (push && (r_tail == PTR_W'(gi))) ? w_push_vld :
            (pop  && (r_head == PTR_W'(gi))) ? 1'b0 :
            (squash && (r_mem[gi].wa == squash_wa)) ? 1'b0 :
            r_vld[gi];
         assign w_hit1[gi] = r_vld[gi] && (r_mem[gi].wa == ra1);
         assign w_hit2[gi] = r_vld[gi] && (r_mem[gi].wa == ra2);
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_vld  <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_vld <= w_vld_next;
         if (push)
            r_tail <= r_tail + 1'b1;
         if (pop)
            r_head <= r_head + 1'b1;
         r_cnt <= r_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         r_mem[r_tail] <= w_push_req;
   end

   assign head_wa  = r_mem[r_head].wa;
   assign head_wd  = r_mem[r_head].wd;
   assign head_vld = r_vld[r_head];
   assign cnt      = r_cnt;
   assign pend1    = (|w_hit1) && is_live_reg(ra1);
   assign pend2    = (|w_hit2) && is_live_reg(ra2);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline (A, priority)
// and a long-latency unit (B, valid/ready), queueing B results that lose.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
)(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    a_we,
   input  logic [4:0]              a_wa,
   input  logic [31:0]             a_wd,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [4:0]              b_wa,
   input  logic [31:0]             b_wd,
   output logic                    we3,
   output logic [4:0]              wa3,
   output logic [31:0]             wd3,
   input  logic [4:0]              ra1,
   input  logic [4:0]              ra2,
   output logic                    pend1,
   output logic                    pend2,
   output logic                    a_hold,
   output logic [$clog2(DEPTH):0]  q_cnt
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SC_W  = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_LAST = SC_W'(STARVE_MAX - 1);

   logic              w_a_req;
   logic              w_b_live;
   logic              w_q_empty;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;
   logic              w_head_lose;
   logic [REG_W-1:0]  w_head_wa;
   logic [DATA_W-1:0] w_head_wd;
   logic              w_head_vld;
   logic [CNT_W-1:0]  w_q_cnt;
   logic [SC_W-1:0]   r_starve;
   logic              r_a_hold;

   assign w_a_req   = a_we && is_live_reg(a_wa);
   assign w_b_live  = is_live_reg(b_wa);
   assign w_q_empty = (w_q_cnt == '0);
   assign b_ready   = (w_q_cnt < CNT_W'(DEPTH));

   // Bypass only when nothing older is queued, so B results stay in order.
   assign w_bypass  = !w_a_req && w_q_empty && b_valid && w_b_live;
   assign w_pop     = !w_a_req && !w_q_empty;
   assign w_push    = b_valid && b_ready && w_b_live && !w_bypass;

   always_comb begin
      we3 = 1'b0;
      wa3 = REG_ZERO;
      wd3 = '0;
      if (w_a_req) begin
         we3 = 1'b1;
         wa3 = a_wa;
         wd3 = a_wd;
      end else if (!w_q_empty) begin
         we3 = w_head_vld;
         wa3 = w_head_wa;
         wd3 = w_head_wd;
      end else if (w_bypass) begin
         we3 = 1'b1;
         wa3 = b_wa;
         wd3 = b_wd;
      end
   end

   rf_wb_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .resetn    (resetn),
      .push      (w_push),
      .push_wa   (b_wa),
      .push_wd   (b_wd),
      .pop       (w_pop),
      .squash    (w_a_req),
      .squash_wa (a_wa),
      .ra1       (ra1),
      .ra2       (ra2),
      .head_wa   (w_head_wa),
      .head_wd   (w_head_wd),
      .head_vld  (w_head_vld),
      .cnt       (w_q_cnt),
      .pend1     (pend1),
      .pend2     (pend2)
   );

   assign w_head_lose = w_a_req && !w_q_empty && w_head_vld;

   // Counter saturates at its last value so a_hold re-fires while A keeps winning.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_starve <= '0;
         r_a_hold <= 1'b0;
      end else begin
         r_a_hold <= w_head_lose && (r_starve == STARVE_LAST);
         if (w_pop || w_q_empty)
            r_starve <= '0;
         else if (w_head_lose && (r_starve != STARVE_LAST))
            r_starve <= r_starve + 1'b1;
      end
   end

   assign a_hold = r_a_hold;
   assign q_cnt  = w_q_cnt;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes go to a
// scoreboard queue; a negedge monitor pops and compares each observed write.
module tb_rf_wb_arbiter;
   logic        clk;
   logic        resetn;
   logic        a_we;
   logic [4:0]  a_wa;
   logic [31:0] a_wd;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_wa;
   logic [31:0] b_wd;
   logic        we3;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        pend1;
   logic        pend2;
   logic        a_hold;
   logic [2:0]  q_cnt;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] rf_model [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .a_we    (a_we),
      .a_wa    (a_wa),
      .a_wd    (a_wd),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_wa    (b_wa),
      .b_wd    (b_wd),
      .we3     (we3),
      .wa3     (wa3),
      .wd3     (wd3),
      .ra1     (ra1),
      .ra2     (ra2),
      .pend1   (pend1),
      .pend2   (pend2),
      .a_hold  (a_hold),
      .q_cnt   (q_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      e.wa = wa;
      e.wd = wd;
      exp_q.push_back(e);
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every write the DUT issues must be the next expected one.
   always @(negedge clk) begin
      if (resetn === 1'b1 && we3 === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_wa", {27'd0, wa3}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_wa", {27'd0, wa3}, {27'd0, e.wa});
            chk("write_wd", wd3, e.wd);
            rf_model[wa3] = wd3;
         end
         $display("[TB] write wa=%0d wd=%08h", wa3, wd3);
      end
   end

   initial begin
      resetn = 1'b1; a_we = 0; a_wa = 0; a_wd = 0;
      b_valid = 0; b_wa = 0; b_wd = 0; ra1 = 0; ra2 = 0;
      #1 resetn = 1'b0;
      #2;
      chk("reset_q_cnt",   {29'd0, q_cnt}, 32'd0);
      chk("reset_b_ready", {31'd0, b_ready}, 32'd1);
      chk("reset_a_hold",  {31'd0, a_hold}, 32'd0);
      chk("reset_we3",     {31'd0, we3}, 32'd0);
      to_pos(); to_pos();
      resetn = 1'b1;
      to_pos();

      // Bypass: empty queue, B goes straight to the write port.
      b_valid = 1; b_wa = 5; b_wd = 32'h1234;
      push_exp(5, 32'h1234);
      to_neg();
      chk("bypass_q_cnt", {29'd0, q_cnt}, 32'd0);
      to_pos();
      b_valid = 0;
      chk("bypass_q_cnt_after", {29'd0, q_cnt}, 32'd0);

      // Conflict: A wins, B queued and drained next cycle.
      a_we = 1; a_wa = 3; a_wd = 32'h333; b_valid = 1; b_wa = 7; b_wd = 32'h777;
      push_exp(3, 32'h333);
      push_exp(7, 32'h777);
      to_neg();
      to_pos();
      a_we = 0; b_valid = 0; ra1 = 7;
      to_neg();
      chk("conflict_q_cnt1", {29'd0, q_cnt}, 32'd1);
      chk("conflict_pend1",  {31'd0, pend1}, 32'd1);
      to_pos();
      chk("conflict_q_cnt0", {29'd0, q_cnt}, 32'd0);
      chk("conflict_pend1_clr", {31'd0, pend1}, 32'd0);
      ra1 = 0;

      // Fill: A holds the port, five B beats, the fifth waits for a pop.
      a_we = 1; a_wa = 1;
      for (int k = 0; k < 4; k++) begin
         a_wd = 32'h100 + k; b_valid = 1; b_wa = 5'(10 + k); b_wd = 32'hB0 + k;
         push_exp(1, a_wd);
         to_neg();
         chk("fill_b_ready", {31'd0, b_ready}, 32'd1);
         to_pos();
      end
      a_wd = 32'h104; b_wa = 14; b_wd = 32'hB4;
      push_exp(1, a_wd);
      to_neg();
      chk("fill_full_ready", {31'd0, b_ready}, 32'd0);
      chk("fill_full_cnt",   {29'd0, q_cnt}, 32'd4);
      to_pos();
      a_we = 0;
      for (int k = 0; k < 5; k++) push_exp(5'(10 + k), 32'hB0 + k);
      to_neg();
      chk("fill_pop_ready", {31'd0, b_ready}, 32'd0);
      chk("fill_pop_cnt",   {29'd0, q_cnt}, 32'd4);
      to_pos();
      chk("fill_after_pop_ready", {31'd0, b_ready}, 32'd1);
      chk("fill_after_pop_cnt",   {29'd0, q_cnt}, 32'd3);
      to_pos();
      b_valid = 0;
      chk("fill_push_pop_cnt", {29'd0, q_cnt}, 32'd3);
      to_pos(); to_pos(); to_pos();
      chk("fill_drained", {29'd0, q_cnt}, 32'd0);

      // WAW squash of a queued entry.
      a_we = 1; a_wa = 2; a_wd = 32'h22; b_valid = 1; b_wa = 9; b_wd = 32'hAA;
      push_exp(2, 32'h22);
      to_pos();
      b_valid = 0; a_wa = 9; a_wd = 32'hBB; ra2 = 9;
      push_exp(9, 32'hBB);
      to_neg();
      chk("waw_pend2_before", {31'd0, pend2}, 32'd1);
      to_pos();
      a_we = 0;
      to_neg();
      chk("waw_pend2_after", {31'd0, pend2}, 32'd0);
      chk("waw_q_cnt",       {29'd0, q_cnt}, 32'd1);
      chk("waw_idle_we3",    {31'd0, we3}, 32'd0);
      to_pos();
      chk("waw_q_empty", {29'd0, q_cnt}, 32'd0);
      ra2 = 0;

      // WAW squash of the incoming beat itself.
      a_we = 1; a_wa = 6; a_wd = 32'h66; b_valid = 1; b_wa = 6; b_wd = 32'h99; ra1 = 6;
      push_exp(6, 32'h66);
      to_pos();
      a_we = 0; b_valid = 0;
      to_neg();
      chk("waw_in_q_cnt", {29'd0, q_cnt}, 32'd1);
      chk("waw_in_pend1", {31'd0, pend1}, 32'd0);
      chk("waw_in_we3",   {31'd0, we3}, 32'd0);
      to_pos();
      ra1 = 0;

      // Starvation: one queued entry, A writes every cycle.
      a_we = 1; a_wa = 4; a_wd = 32'h400; b_valid = 1; b_wa = 8; b_wd = 32'h88;
      push_exp(4, a_wd);
      to_pos();
      b_valid = 0;
      for (int i = 1; i <= 8; i++) begin
         a_wd = 32'h400 + i;
         push_exp(4, a_wd);
         to_neg();
         chk("starve_no_hold", {31'd0, a_hold}, 32'd0);
         to_pos();
      end
      a_wd = 32'h409;
      push_exp(4, a_wd);
      to_neg();
      chk("starve_hold_c9", {31'd0, a_hold}, 32'd1);
      to_pos();
      a_we = 0;
      push_exp(8, 32'h88);
      to_neg();
      chk("starve_hold_c10", {31'd0, a_hold}, 32'd1);
      to_pos();
      chk("starve_hold_clr", {31'd0, a_hold}, 32'd0);
      chk("starve_q_empty",  {29'd0, q_cnt}, 32'd0);

      // Mid-operation reset with three queued entries.
      a_we = 1; a_wa = 1;
      for (int k = 0; k < 3; k++) begin
         a_wd = 32'h500 + k; b_valid = 1; b_wa = 5'(20 + k); b_wd = 32'hC0 + k;
         push_exp(1, a_wd);
         to_pos();
      end
      b_valid = 0; a_we = 0; ra1 = 20; ra2 = 21;
      resetn = 1'b0;
      #1;
      chk("rst_q_cnt",   {29'd0, q_cnt}, 32'd0);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
      chk("rst_a_hold",  {31'd0, a_hold}, 32'd0);
      chk("rst_pend1",   {31'd0, pend1}, 32'd0);
      chk("rst_pend2",   {31'd0, pend2}, 32'd0);
      to_pos(); to_pos();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         to_neg();
         chk("post_rst_we3", {31'd0, we3}, 32'd0);
         to_pos();
      end
      chk("post_rst_q_cnt", {29'd0, q_cnt}, 32'd0);

      chk("reg9_final", rf_model[9], 32'hBB);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
